// File: rtl/cvxif_instr_pkg.sv
// Coprocessor instruction definitions shared by the decoder and the issue queue.
//
// Contents:
//   NbRegRead          width of the register_read field (rs1/rs2/rs3)
//   opcode_t           internal operation code carried to the dispatch side
//   copro_instr_t      one decode-table entry {instr, mask, accept, writeback,
//                      register_read, opcode}
//   CoproInstrDefault  default two-entry table (NOP, FXMADD)
//   rs_covered()       checks that every source register an entry reads
//                      has a valid operand
package cvxif_instr_pkg;

   localparam int unsigned NbRegRead = 3;

   typedef enum logic [3:0] {
      ILLEGAL = 4'b0000,
      NOP     = 4'b0001,
      FXMADD  = 4'b0010
   } opcode_t;

   typedef struct packed {
      logic [31:0]          instr;
      logic [31:0]          mask;
      logic                 accept;
      logic                 writeback;
      logic [NbRegRead-1:0] register_read;
      opcode_t              opcode;
   } copro_instr_t;

   localparam int unsigned NbInstrDefault = 2;

   // NOP is an exact match on custom-3 with all other bits zero.
   // FXMADD only constrains opcode and funct3, so rd/rs fields are free.
   localparam copro_instr_t CoproInstrDefault [NbInstrDefault] = '{
      '{instr: 32'h0000_007B, mask: 32'hFFFF_FFFF, accept: 1'b1, writeback: 1'b0,
        register_read: 3'b000, opcode: NOP},
      '{instr: 32'h0000_002B, mask: 32'h0000_707F, accept: 1'b1, writeback: 1'b1,
        register_read: 3'b111, opcode: FXMADD}
   };

   // True when every register the instruction reads has a valid operand.
   function automatic logic rs_covered(input logic [NbRegRead-1:0] need,
                                       input logic [NbRegRead-1:0] have);
      return (need & ~have) == '0;
   endfunction

endpackage

// File: rtl/cvxif_instr_decoder.sv
// Combinational decoder for coprocessor instructions.
//
// Ports:
//   instr      in  32         instruction word offered on the issue interface
//   rs_valid   in  NbRegRead  which source operands are valid
//   accept     out 1          instruction is known, acceptable and has its operands
//   writeback  out 1          accepted instruction writes a result back
//   opcode     out 4          decoded operation (ILLEGAL when nothing matches)
module cvxif_instr_decoder
   import cvxif_instr_pkg::*;
#(
   parameter int unsigned  NbInstr                = 2,
   parameter copro_instr_t CoproInstr [NbInstr]   = CoproInstrDefault
) (
   input  logic [31:0]          instr,
   input  logic [NbRegRead-1:0] rs_valid,
   output logic                 accept,
   output logic                 writeback,
   output logic [3:0]           opcode
);

   logic [NbInstr-1:0] hit;

   for (genvar gi = 0; gi < NbInstr; gi++) begin : g_match
      assign hit[gi] = ((instr & CoproInstr[gi].mask) == CoproInstr[gi].instr);
   end

   // Walk from the highest index down so the lowest matching entry is the
   // last one assigned and therefore wins.
   always_comb begin
      accept    = 1'b0;
      writeback = 1'b0;
      opcode    = ILLEGAL;
      for (int k = int'(NbInstr) - 1; k >= 0; k--) begin
         if (hit[k]) begin
            accept    = CoproInstr[k].accept &&
                        rs_covered(CoproInstr[k].register_read, rs_valid);
            writeback = CoproInstr[k].accept &&
                        rs_covered(CoproInstr[k].register_read, rs_valid) &&
                        CoproInstr[k].writeback;
            opcode    = CoproInstr[k].opcode;
         end
      end
   end

endmodule

// File: rtl/cvxif_issue_queue.sv
// In-order issue queue between a CV-X-IF issue/commit interface and a
// coprocessor execution unit.
//
// Instructions are decoded and answered in the handshake cycle, stored at the
// tail, and leave from the head only once their commit has arrived. A killed
// head is dropped without a dispatch handshake. Younger entries never bypass
// an uncommitted head.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   issue_valid_i/issue_ready_o  issue handshake
//   issue_instr_i                instruction word (32)
//   issue_id_i                   instruction id (IdWidth)
//   issue_rs_i, issue_rs_valid_i source operands (3xXLEN) and their valid bits
//   issue_accept_o               zero-latency accept response
//   issue_writeback_o            zero-latency writeback response
//   commit_valid_i, commit_id_i  commit of one id
//   commit_kill_i                the committed id is to be discarded
//   disp_valid_o/disp_ready_i    dispatch handshake
//   disp_opcode_o, disp_id_o, disp_rs_o, disp_writeback_o  head entry payload
//   flush_i                      empty the queue (overrides a same-cycle push)
//   count_o                      occupancy
module cvxif_issue_queue
   import cvxif_instr_pkg::*;
#(
   parameter int unsigned  XLEN                 = 32,
   parameter int unsigned  IdWidth              = 3,
   parameter int unsigned  Depth                = 4,
   parameter int unsigned  NbInstr              = 2,
   parameter copro_instr_t CoproInstr [NbInstr] = CoproInstrDefault
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // issue
   input  logic                  issue_valid_i,
   output logic                  issue_ready_o,
   input  logic [31:0]           issue_instr_i,
   input  logic [IdWidth-1:0]    issue_id_i,
   input  logic [3*XLEN-1:0]     issue_rs_i,
   input  logic [2:0]            issue_rs_valid_i,
   output logic                  issue_accept_o,
   output logic                  issue_writeback_o,
   // commit
   input  logic                  commit_valid_i,
   input  logic [IdWidth-1:0]    commit_id_i,
   input  logic                  commit_kill_i,
   // dispatch
   output logic                  disp_valid_o,
   input  logic                  disp_ready_i,
   output logic [3:0]            disp_opcode_o,
   output logic [IdWidth-1:0]    disp_id_o,
   output logic [3*XLEN-1:0]     disp_rs_o,
   output logic                  disp_writeback_o,
   // status
   input  logic                  flush_i,
   output logic [$clog2(Depth):0] count_o
);

   localparam int unsigned PtrW = $clog2(Depth);

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic       dec_accept;
   logic       dec_writeback;
   logic [3:0] dec_opcode;

   cvxif_instr_decoder #(
      .NbInstr    (NbInstr),
      .CoproInstr (CoproInstr)
   ) u_decoder (
      .instr     (issue_instr_i),
      .rs_valid  (issue_rs_valid_i),
      .accept    (dec_accept),
      .writeback (dec_writeback),
      .opcode    (dec_opcode)
   );

   assign issue_accept_o    = dec_accept;
   assign issue_writeback_o = dec_writeback;

   // ------------------------------------------------------------------
   // Queue state
   // ------------------------------------------------------------------
   logic [PtrW-1:0]  head_reg;
   logic [PtrW-1:0]  tail_reg;
   logic [PtrW:0]    count_reg;
   logic [PtrW:0]    count_next;

   logic [Depth-1:0] valid_vec;
   logic [Depth-1:0] committed_vec;
   logic [Depth-1:0] killed_vec;

   // Payload storage; written only on push, never reset.
   logic [3:0]         opcode_mem [Depth];
   logic [IdWidth-1:0] id_mem     [Depth];
   logic [3*XLEN-1:0]  rs_mem     [Depth];
   logic [Depth-1:0]   wb_mem;

   logic head_valid;
   logic head_committed;
   logic head_killed;
   logic full;
   logic push;
   logic pop;
   logic drop;
   logic dispatch;
   logic commit_new;

   assign head_valid     = valid_vec[head_reg];
   assign head_committed = committed_vec[head_reg];
   assign head_killed    = killed_vec[head_reg];
   assign full           = (count_reg == (PtrW+1)'(Depth));

   // Reset blocks any dispatch or drop in its own cycle.
   assign disp_valid_o = !rst_i && head_valid && head_committed && !head_killed;
   assign dispatch     = disp_valid_o && disp_ready_i;
   assign drop         = !rst_i && head_valid && head_killed;
   assign pop          = dispatch || drop;

   // A slot freed this cycle can be reused by a push in the same cycle.
   assign issue_ready_o = !full || pop;
   assign push          = issue_valid_i && issue_ready_o && dec_accept && !flush_i && !rst_i;

   // A commit for the id being issued right now lands on the new entry.
   assign commit_new = commit_valid_i && (commit_id_i == issue_id_i);

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (push) tail_reg <= tail_reg + 1'b1;
         if (pop)  head_reg <= head_reg + 1'b1;
         count_reg <= count_next;
      end
   end

   // ------------------------------------------------------------------
   // Per-entry status bits
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
      logic valid_reg;
      logic committed_reg;
      logic killed_reg;
      logic push_here;
      logic pop_here;
      logic commit_here;

      assign push_here   = push && (tail_reg == PtrW'(gi));
      assign pop_here    = pop  && (head_reg == PtrW'(gi));
      assign commit_here = commit_valid_i && valid_reg && (id_mem[gi] == commit_id_i);

      // When full, head and tail share a slot; the push must win over the
      // pop so the new entry is not cleared as the old one leaves.
      always_ff @(posedge clk_i) begin
         if (rst_i || flush_i) begin
            valid_reg     <= 1'b0;
            committed_reg <= 1'b0;
            killed_reg    <= 1'b0;
         end else if (push_here) begin
            valid_reg     <= 1'b1;
            committed_reg <= commit_new;
            killed_reg    <= commit_new && commit_kill_i;
         end else if (pop_here) begin
            valid_reg     <= 1'b0;
            committed_reg <= 1'b0;
            killed_reg    <= 1'b0;
         end else if (commit_here) begin
            committed_reg <= 1'b1;
            killed_reg    <= commit_kill_i;
         end
      end

      assign valid_vec[gi]     = valid_reg;
      assign committed_vec[gi] = committed_reg;
      assign killed_vec[gi]    = killed_reg;
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         opcode_mem[tail_reg] <= dec_opcode;
         id_mem[tail_reg]     <= issue_id_i;
         rs_mem[tail_reg]     <= issue_rs_i;
         wb_mem[tail_reg]     <= dec_writeback;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign disp_opcode_o    = opcode_mem[head_reg];
   assign disp_id_o        = id_mem[head_reg];
   assign disp_rs_o        = rs_mem[head_reg];
   assign disp_writeback_o = wb_mem[head_reg];
   assign count_o          = count_reg;

endmodule
